// File: rtl/pio_reg_pkg.sv
// Shared definitions for the PIO register block and its APB bridge.
package pio_reg_pkg;

  localparam int ADDR_WIDTH = 8;   // word-offset width into pio_regs
  localparam int DATA_WIDTH = 32;  // register data width

  // Bridge sequencing: setup capture, downstream request, read capture,
  // completion, and immediate decode-error completion.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    DONE,
    ERR
  } bridge_state_e;

  // One APB transfer as presented to pio_regs.
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] data;
  } apb_req_t;

endpackage

// File: rtl/pio_busy_timer.sv
// Counts cycles a request spends stalled on busy. tc_o flags that the next
// increment reaches TIMEOUT, so the caller can abort on that same edge.
module pio_busy_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count_q;

  // Saturating counter: clear wins over increment, holds at TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q >= LAST);

endmodule

// File: rtl/pio_apb_bridge.sv
// APB3 slave front-end for pio_regs: turns an APB transfer into a held
// sel/RW/addr/wdata request, waits out busy (bounded by TIMEOUT), and
// returns registered prdata/pready/pslverr.
module pio_apb_bridge
  import pio_reg_pkg::*;
#(
  parameter int PADDR_WIDTH = 12,
  parameter int NUM_REGS    = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]  pwdata,
  output logic [DATA_WIDTH-1:0]  prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   sel,
  output logic                   RW,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0]  wdata,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic                   busy,
  output logic                   tout_evt
);

  localparam int OFF_W = PADDR_WIDTH - 2;

  bridge_state_e         state_q;
  apb_req_t              req_q;
  apb_req_t              req_d;
  logic                  sel_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic                  tout_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [OFF_W-1:0]      off_full;
  logic                  req_ok;
  logic                  tmr_tc;

  // Decode the setup-phase address and assemble the candidate request.
  always_comb begin
    off_full     = paddr[PADDR_WIDTH-1:2];
    req_ok       = (paddr[1:0] == 2'b00) && (off_full < OFF_W'(NUM_REGS));
    req_d.write  = pwrite;
    req_d.offset = ADDR_WIDTH'(off_full);
    req_d.data   = pwdata;
  end

  pio_busy_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_busy_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != REQ),
    .inc_i ((state_q == REQ) && busy),
    .tc_o  (tmr_tc)
  );

  // Transfer sequencer with registered APB and pio_regs outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      sel_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tout_q    <= 1'b0;
      prdata_q  <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only on the
      // edge that enters DONE/ERR, so each lasts exactly one cycle; all
      // state uses non-blocking assignments so branches see old values.
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tout_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            if (req_ok) begin
              state_q <= REQ;
              sel_q   <= 1'b1;
              req_q   <= req_d;
            end else begin
              state_q   <= ERR;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end
          end
        end
        REQ: begin
          if (!busy) begin
            sel_q   <= 1'b0;
            state_q <= CAPT;
          end else if (tmr_tc) begin
            sel_q     <= 1'b0;
            state_q   <= DONE;
            tout_q    <= 1'b1;
            pready_q  <= psel;
            pslverr_q <= psel;
          end
        end
        CAPT: begin
          prdata_q <= req_q.write ? '0 : rdata;
          pready_q <= psel;
          state_q  <= DONE;
        end
        DONE, ERR: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign sel      = sel_q;
  assign RW       = req_q.write;
  assign addr     = req_q.offset;
  assign wdata    = req_q.data;
  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign tout_evt = tout_q;

endmodule

// File: tb/tb_pio_apb_bridge.sv
// Directed bench for pio_apb_bridge with hand-computed expectations.
module tb_pio_apb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        sel, RW;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        tout_evt;

  int checks = 0;
  int errors = 0;

  pio_apb_bridge #(
    .PADDR_WIDTH(12),
    .NUM_REGS   (8),
    .TIMEOUT    (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .sel     (sel),
    .RW      (RW),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .tout_evt(tout_evt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic wr, input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_idle(); pwrite = 1'b0; paddr = '0; pwdata = '0;
    rdata = '0; busy = 1'b0;
    tick(); tick();
    checks++; if (sel !== 1'b0)      begin errors++; $display("FAIL rst_sel: got %0b exp 0", sel); end
    checks++; if (pready !== 1'b0)   begin errors++; $display("FAIL rst_pready: got %0b exp 0", pready); end
    checks++; if (pslverr !== 1'b0)  begin errors++; $display("FAIL rst_pslverr: got %0b exp 0", pslverr); end
    checks++; if (tout_evt !== 1'b0) begin errors++; $display("FAIL rst_tout: got %0b exp 0", tout_evt); end
    checks++; if (prdata !== 32'h0)  begin errors++; $display("FAIL rst_prdata: got %h exp 0", prdata); end
    checks++; if ({RW, addr, wdata} !== 41'h0) begin errors++; $display("FAIL rst_req: got %b/%h/%h exp 0", RW, addr, wdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    setup(1'b1, 12'h008, 32'hDEADBEEF);
    tick();  // T1
    checks++; if (sel !== 1'b1)          begin errors++; $display("FAIL wr_sel_t1: got %0b exp 1", sel); end
    checks++; if (addr !== 8'd2)         begin errors++; $display("FAIL wr_addr: got %0d exp 2", addr); end
    checks++; if (RW !== 1'b1)           begin errors++; $display("FAIL wr_rw: got %0b exp 1", RW); end
    checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h exp deadbeef", wdata); end
    checks++; if (pready !== 1'b0)       begin errors++; $display("FAIL wr_pready_t1: got %0b exp 0", pready); end
    penable = 1'b1;
    tick();  // T2
    checks++; if (sel !== 1'b0)    begin errors++; $display("FAIL wr_sel_t2: got %0b exp 0", sel); end
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL wr_pready_t2: got %0b exp 0", pready); end
    tick();  // T3
    checks++; if (pready !== 1'b1)  begin errors++; $display("FAIL wr_pready_t3: got %0b exp 1", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL wr_pslverr: got %0b exp 0", pslverr); end
    bus_idle();
    tick();
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL wr_pready_t4: got %0b exp 0", pready); end
  endtask

  task automatic test_busy_wait();
    setup(1'b1, 12'h00C, 32'h0BADF00D);
    busy = 1'b1;
    tick();  // T1
    penable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL bw_sel_hold%0d: got %0b exp 1", i, sel); end
      tick();
    end
    busy = 1'b0;  // T6: accepted
    checks++; if (sel !== 1'b1 || addr !== 8'd3) begin errors++; $display("FAIL bw_sel_t6: got sel=%0b addr=%0d exp 1/3", sel, addr); end
    tick();  // T7
    checks++; if (sel !== 1'b0 || pready !== 1'b0) begin errors++; $display("FAIL bw_t7: got sel=%0b pready=%0b exp 0/0", sel, pready); end
    tick();  // T8
    checks++; if (pready !== 1'b1 || pslverr !== 1'b0) begin errors++; $display("FAIL bw_done: got pready=%0b pslverr=%0b exp 1/0", pready, pslverr); end
    bus_idle();
    tick();
  endtask

  task automatic test_read();
    setup(1'b0, 12'h004, 32'h0);
    rdata = 32'hAAAAAAAA;
    tick();  // T1
    checks++; if (sel !== 1'b1 || addr !== 8'd1 || RW !== 1'b0) begin errors++; $display("FAIL rd_req: got sel=%0b addr=%0d rw=%0b exp 1/1/0", sel, addr, RW); end
    penable = 1'b1;
    tick();  // T2: capture cycle
    rdata = 32'h12345678;
    tick();  // T3
    checks++; if (pready !== 1'b1 || pslverr !== 1'b0) begin errors++; $display("FAIL rd_done: got pready=%0b pslverr=%0b exp 1/0", pready, pslverr); end
    checks++; if (prdata !== 32'h12345678) begin errors++; $display("FAIL rd_prdata: got %h exp 12345678", prdata); end
    bus_idle();
    rdata = 32'h0;
    tick();
    checks++; if (prdata !== 32'h12345678 || pready !== 1'b0) begin errors++; $display("FAIL rd_hold: got prdata=%h pready=%0b exp 12345678/0", prdata, pready); end
  endtask

  task automatic test_timeout();
    int n;
    setup(1'b0, 12'h000, 32'h0);
    busy = 1'b1;
    tick();  // T1
    penable = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && sel === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL to_sel_cycles: got %0d exp 16", n); end
    checks++; if (tout_evt !== 1'b1) begin errors++; $display("FAIL to_evt: got %0b exp 1", tout_evt); end
    checks++; if (pready !== 1'b1 || pslverr !== 1'b1) begin errors++; $display("FAIL to_done: got pready=%0b pslverr=%0b exp 1/1", pready, pslverr); end
    checks++; if (prdata !== 32'h12345678) begin errors++; $display("FAIL to_prdata_hold: got %h exp 12345678", prdata); end
    bus_idle();
    busy = 1'b0;
    tick();
    checks++; if (tout_evt !== 1'b0 || pready !== 1'b0) begin errors++; $display("FAIL to_after: got tout=%0b pready=%0b exp 0/0", tout_evt, pready); end
  endtask

  task automatic test_decode_err();
    setup(1'b0, 12'h020, 32'h0);  // offset 8 == NUM_REGS
    tick();
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL de_range_sel: got %0b exp 0", sel); end
    checks++; if (pready !== 1'b1 || pslverr !== 1'b1) begin errors++; $display("FAIL de_range_resp: got pready=%0b pslverr=%0b exp 1/1", pready, pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL de_range_prdata: got %h exp 0", prdata); end
    bus_idle();
    tick();
    checks++; if (pready !== 1'b0 || pslverr !== 1'b0) begin errors++; $display("FAIL de_range_clear: got pready=%0b pslverr=%0b exp 0/0", pready, pslverr); end
    setup(1'b1, 12'h005, 32'h11111111);  // unaligned
    tick();
    checks++; if (sel !== 1'b0 || pready !== 1'b1 || pslverr !== 1'b1) begin errors++; $display("FAIL de_unal: got sel=%0b pready=%0b pslverr=%0b exp 0/1/1", sel, pready, pslverr); end
    bus_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    setup(1'b0, 12'h01C, 32'h0);  // last valid offset 7
    tick();  // T1
    checks++; if (sel !== 1'b1 || addr !== 8'd7) begin errors++; $display("FAIL b2b_req1: got sel=%0b addr=%0d exp 1/7", sel, addr); end
    penable = 1'b1;
    tick();  // T2
    rdata = 32'h77770007;
    tick();  // T3
    checks++; if (pready !== 1'b1 || prdata !== 32'h77770007) begin errors++; $display("FAIL b2b_done1: got pready=%0b prdata=%h exp 1/77770007", pready, prdata); end
    tick();  // T4: next setup immediately
    setup(1'b0, 12'h018, 32'h0);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL b2b_pready_gap: got %0b exp 0", pready); end
    tick();  // T5
    checks++; if (sel !== 1'b1 || addr !== 8'd6) begin errors++; $display("FAIL b2b_req2: got sel=%0b addr=%0d exp 1/6", sel, addr); end
    penable = 1'b1;
    tick();  // T6
    rdata = 32'h66660006;
    tick();  // T7
    checks++; if (pready !== 1'b1 || prdata !== 32'h66660006) begin errors++; $display("FAIL b2b_done2: got pready=%0b prdata=%h exp 1/66660006", pready, prdata); end
    bus_idle();
    tick();
  endtask

  task automatic test_psel_drop();
    setup(1'b1, 12'h000, 32'h00000001);
    tick();  // T1
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL drop_sel: got %0b exp 1", sel); end
    bus_idle();
    tick();  // T2
    tick();  // T3
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL drop_pready: got %0b exp 0", pready); end
    tick();
  endtask

  task automatic test_reset_mid();
    setup(1'b1, 12'h010, 32'hA5A5A5A5);
    busy = 1'b1;
    tick();  // T1
    penable = 1'b1;
    checks++; if (sel !== 1'b1 || addr !== 8'd4) begin errors++; $display("FAIL rm_req: got sel=%0b addr=%0d exp 1/4", sel, addr); end
    repeat (15) tick();  // T16: timeout would fire on this edge
    reset = 1'b1;
    tick();
    checks++; if (sel !== 1'b0 || pready !== 1'b0 || tout_evt !== 1'b0) begin errors++; $display("FAIL rm_abort: got sel=%0b pready=%0b tout=%0b exp 0/0/0", sel, pready, tout_evt); end
    checks++; if ({RW, addr, wdata} !== 41'h0) begin errors++; $display("FAIL rm_req_clr: got %b/%h/%h exp 0", RW, addr, wdata); end
    reset = 1'b0; busy = 1'b0; bus_idle();
    tick();
    setup(1'b0, 12'h000, 32'h0);
    tick();  // T1
    checks++; if (sel !== 1'b1 || addr !== 8'd0 || RW !== 1'b0) begin errors++; $display("FAIL rm_rd_req: got sel=%0b addr=%0d rw=%0b exp 1/0/0", sel, addr, RW); end
    penable = 1'b1;
    tick();  // T2
    rdata = 32'hCAFEF00D;
    tick();  // T3
    checks++; if (pready !== 1'b1 || pslverr !== 1'b0 || prdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rm_rd_done: got pready=%0b pslverr=%0b prdata=%h exp 1/0/cafef00d", pready, pslverr, prdata); end
    bus_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_busy_wait();
    test_read();
    test_timeout();
    test_decode_err();
    test_back_to_back();
    test_psel_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pio_apb_bridge.md
Name: pio_apb_bridge

Overview:
- APB3 slave front-end that sits directly upstream of pio_regs: it converts APB transfers into the pio_regs sel/RW/addr/wdata request and honours the pio_regs busy flag.
- Returns read data and completion to the APB master. Flags decode errors and busy timeouts via pslverr.
- One instance per PIO block, between the system APB interconnect and pio_regs.

Parameters:
- PADDR_WIDTH, 12, APB byte-address width.
- NUM_REGS, 8, number of 32-bit-word registers implemented in pio_regs; valid word offsets are 0..NUM_REGS-1.
- TIMEOUT, 16, maximum cycles sel may be held while busy=1 before the access is aborted; must be ≥1.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- psel  in  1  APB slave select.
- penable  in  1  APB access-phase strobe.
- pwrite  in  1  APB direction, 1=write.
- paddr  in  PADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- prdata  out  DATA_WIDTH  APB read data, registered.
- pready  out  1  APB transfer complete, registered.
- pslverr  out  1  APB error, valid only with pready.
- sel  out  1  request to pio_regs.
- RW  out  1  to pio_regs, 1=write, 0=read.
- addr  out  ADDR_WIDTH  word offset to pio_regs.
- wdata  out  DATA_WIDTH  write data to pio_regs.
- rdata  in  DATA_WIDTH  read data from pio_regs, valid the cycle after acceptance.
- busy  in  1  pio_regs cannot accept a request.
- tout_evt  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-transfer abandons it; sel and pready are 0 from the next edge.
- States and transitions:
  - IDLE: on psel=1 and penable=0, capture pwrite, pwdata and word offset paddr[PADDR_WIDTH-1:2].
    - Go to ERR if paddr[1:0]≠0 or offset ≥ NUM_REGS.
    - Otherwise go to REQ, with sel=1 and addr/RW/wdata loaded on the same edge.
  - REQ: sel held at 1 and addr/RW/wdata stable.
    - Acceptance is any cycle with sel=1 and busy=0; go to CAPT with sel=0 on the next edge.
    - Each cycle with busy=1 increments the counter. When the counter reaches TIMEOUT: sel→0, go to DONE with error, tout_evt=1 for one cycle.
  - CAPT: prdata←rdata for reads, prdata←0 for writes; go to DONE.
  - DONE: pready=1 for exactly one cycle; pslverr=1 only for a timeout path. Next state IDLE; counter clears.
  - ERR: pready=1 and pslverr=1 for one cycle, prdata=0, no sel issued; next state IDLE.
- Latency: with busy=0, setup at T0 → sel=1 at T1 → CAPT at T2 → pready at T3 (3 wait-free cycles). An error returns pready at T1.
- Master drops psel before completion (protocol violation): the downstream request still completes; in DONE/ERR, pready is not asserted if psel=0; return to IDLE.
- Back-to-back transfers: a setup phase presented in the cycle after pready is captured with no bubble.
- pready and pslverr are never 1 outside DONE/ERR. sel is never asserted in ERR.
- prdata holds its last value except where updated in CAPT/ERR.
- Counter width is $clog2(TIMEOUT+1) and it saturates at TIMEOUT.

Decomposition:
- pio_reg_pkg supplies ADDR_WIDTH and DATA_WIDTH.
- Add to pio_reg_pkg: the state enum typedef (IDLE, REQ, CAPT, DONE, ERR) and an APB request struct (write flag, offset, data).
- Split out one sub-module, pio_busy_timer: a load/clear/increment counter with terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Write 0xDEADBEEF to paddr 0x008 with busy=0 → sel=1 for one cycle with addr=2, RW=1, wdata=0xDEADBEEF; pready=1 at T3; pslverr=0.
- Read paddr 0x004 with busy=0 and rdata=0x1234_5678 in CAPT → prdata=0x12345678 with pready at T3; pslverr=0.
- Write to paddr 0x00C with busy held 1 for 5 cycles → sel stays 1 for 6 cycles; accepted on the 6th; pready 2 cycles later; no error.
- Read with busy stuck at 1 and TIMEOUT=16 → sel drops after 16 busy cycles; tout_evt pulses once; pready=1 and pslverr=1.
- Access paddr 0x020 (offset 8 = NUM_REGS) and access paddr 0x005 (unaligned) → no sel; pready=1 and pslverr=1 at T1; prdata=0.
- Assert reset in REQ with busy=1 → sel, pready and tout_evt are 0 next cycle; a following read to 0x000 completes normally.
